// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word access to a word-addressed memory.
// Sub-word stores are read-modify-write; loads are zero/sign extended.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [M+1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [M-1:0] mem_address,
    output logic         mem_wf,
    output logic [N-1:0] mem_w,
    input  logic [N-1:0] mem_v
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           we_q;
    logic [1:0]     size_q;
    logic           sgn_q;
    logic [M+1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic [N-1:0]   data_q;
    logic           enter_resp;
    logic [N-1:0]   rdata_d;
    logic           err_d;

    function automatic logic bad_access(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        unique case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [N-1:0] extract(
        input logic [N-1:0] word,
        input logic [1:0]   size,
        input logic         sgn,
        input logic [1:0]   lo
    );
        logic [N-1:0] sh;
        logic [N-1:0] res;
        sh = word >> {lo, 3'b000};
        unique case (size)
            SZ_B:    res = {{(N-8){sgn & sh[7]}}, sh[7:0]};
            SZ_H:    res = {{(N-16){sgn & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // Replace only the addressed lanes of the previously read word.
    function automatic logic [N-1:0] merge(
        input logic [N-1:0] old,
        input logic [N-1:0] wdata,
        input logic [1:0]   size,
        input logic [1:0]   lo
    );
        logic [N-1:0] mask;
        logic [N-1:0] ins;
        unique case (size)
            SZ_B:    mask = {{(N-8){1'b0}}, 8'hFF} << {lo, 3'b000};
            SZ_H:    mask = {{(N-16){1'b0}}, 16'hFFFF} << {lo, 3'b000};
            default: mask = '1;
        endcase
        ins = wdata << {lo, 3'b000};
        return (old & ~mask) | (ins & mask);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        enter_resp = 1'b0;
        rdata_d    = '0;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad_access(req_size, req_addr[1:0])) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        err_d      = 1'b1;
                    end else if (req_we && req_size == SZ_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    rdata_d    = extract(mem_v, size_q, sgn_q,
                                         addr_q[1:0]);
                end
            end
            WRITE: begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (state_q == READ) begin
            data_q <= mem_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
        end
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        mem_wf      = (state_q == WRITE);
        mem_address = '0;
        mem_w       = '0;
        if (state_q == READ || state_q == WRITE) begin
            mem_address = addr_q[M+1:2];
        end
        if (state_q == WRITE) begin
            if (size_q == SZ_W) begin
                mem_w = wdata_q;
            end else begin
                mem_w = merge(data_q, wdata_q, size_q, addr_q[1:0]);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset abort,
// back-to-back loads and random traffic against a byte-level model.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_address;
    logic        mem_wf;
    logic [31:0] mem_w;
    logic [31:0] mem_v;

    logic [31:0] dmem    [0:65535];
    logic [31:0] ref_mem [0:65535];

    int checks;
    int failures;

    load_store_unit #(.N(32), .M(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_address(mem_address),
        .mem_wf     (mem_wf),
        .mem_w      (mem_w),
        .mem_v      (mem_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_v = dmem[mem_address];
    always @(posedge clk) begin
        if (mem_wf) dmem[mem_address] <= mem_w;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte-level reference: each access touches nb bytes at addr.
    function automatic void model(
        input logic we, input logic [1:0] size, input logic sgn,
        input logic [17:0] addr, input logic [31:0] wdata,
        output logic [31:0] rd, output logic err,
        output int lat, output logic wf
    );
        int nb;
        int widx;
        int off;
        longint val;
        nb   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        widx = int'(addr) / 4;
        off  = int'(addr) % 4;
        rd   = 0;
        if (size == 3 || (int'(addr) % nb) != 0) begin
            err = 1; lat = 1; wf = 0;
            return;
        end
        err = 0;
        if (we) begin
            for (int b = 0; b < nb; b++)
                ref_mem[widx][8*(off+b) +: 8] = wdata[8*b +: 8];
            lat = (nb == 4) ? 2 : 3;
            wf  = 1;
        end else begin
            val = 0;
            for (int b = 0; b < nb; b++)
                val += longint'(ref_mem[widx][8*(off+b) +: 8]) << (8*b);
            if (sgn && val >= (64'sd1 << (8*nb-1)))
                val -= (64'sd1 << (8*nb));
            rd  = val[31:0];
            lat = 2;
            wf  = 0;
        end
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 10 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_req(
        input logic we, input logic [1:0] size, input logic sgn,
        input logic [17:0] addr, input logic [31:0] wdata,
        output logic [31:0] rd, output logic err, output int lat,
        output logic wf_seen, output logic [31:0] wv
    );
        wait_ready();
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 99; rd = 'x; err = 'x;
        wf_seen = 0; wv = 0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_wf) begin
                wf_seen = 1;
                wv = mem_w;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        wf;
        logic [31:0] w;
    } vec_t;

    vec_t vt[13];

    logic [31:0] a_rd, e_rd, a_w;
    logic        a_err, e_err, a_wf, e_wf;
    int          a_lat, e_lat;
    logic        seen;
    int          acc_c[3];
    int          rsp_c[3];
    logic [31:0] rsp_d[3];
    logic [31:0] exp_d[3];
    int          n_acc, n_rsp;
    logic        rdy_now;

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 65536; i++) begin
            dmem[i] = 0;
            ref_mem[i] = 0;
        end
        rst = 1; req_valid = 0; req_we = 0; req_size = 0;
        req_signed = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_mem_wf", 32'(mem_wf), 0);
        rst = 0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);

        vt[0]  = '{1, 2, 0, 18'h10, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF};
        vt[1]  = '{0, 2, 0, 18'h10, 0, 32'hDEADBEEF, 0, 2, 0, 0};
        vt[2]  = '{1, 0, 0, 18'h12, 32'hABCDEF55, 0, 0, 3, 1, 32'hDE55BEEF};
        vt[3]  = '{0, 2, 0, 18'h10, 0, 32'hDE55BEEF, 0, 2, 0, 0};
        vt[4]  = '{0, 1, 1, 18'h12, 0, 32'hFFFFDE55, 0, 2, 0, 0};
        vt[5]  = '{0, 1, 0, 18'h12, 0, 32'h0000DE55, 0, 2, 0, 0};
        vt[6]  = '{0, 0, 1, 18'h10, 0, 32'hFFFFFFEF, 0, 2, 0, 0};
        vt[7]  = '{0, 2, 0, 18'h11, 0, 0, 1, 1, 0, 0};
        vt[8]  = '{1, 1, 0, 18'h13, 32'h1234, 0, 1, 1, 0, 0};
        vt[9]  = '{0, 3, 0, 18'h10, 0, 0, 1, 1, 0, 0};
        vt[10] = '{0, 2, 0, 18'h10, 0, 32'hDE55BEEF, 0, 2, 0, 0};
        vt[11] = '{1, 1, 0, 18'h16, 32'hA5A58001, 0, 0, 3, 1, 32'h80010000};
        vt[12] = '{0, 0, 0, 18'h17, 0, 32'h00000080, 0, 2, 0, 0};

        for (int i = 0; i < 13; i++) begin
            model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr,
                  vt[i].wdata, e_rd, e_err, e_lat, e_wf);
            do_req(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr,
                   vt[i].wdata, a_rd, a_err, a_lat, a_wf, a_w);
            chk($sformatf("vec%0d_rdata", i), a_rd, vt[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vt[i].err));
            chk($sformatf("vec%0d_lat", i), a_lat, vt[i].lat);
            chk($sformatf("vec%0d_wf", i), 32'(a_wf), 32'(vt[i].wf));
            if (vt[i].wf)
                chk($sformatf("vec%0d_mem_w", i), a_w, vt[i].w);
        end
        chk("err_mem_unchanged", dmem[4], 32'hDE55BEEF);

        // Reset during the WRITE cycle of a byte store.
        model(1, 2, 0, 18'h40, 32'h11223344, e_rd, e_err, e_lat, e_wf);
        do_req(1, 2, 0, 18'h40, 32'h11223344, a_rd, a_err, a_lat,
               a_wf, a_w);
        wait_ready();
        req_we = 1; req_size = 0; req_signed = 0;
        req_addr = 18'h41; req_wdata = 32'h99;
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("abort_wf_before", 32'(mem_wf), 1);
        chk("abort_mem_w", mem_w, 32'h11229944);
        rst = 1;
        #1;
        chk("abort_wf_dropped", 32'(mem_wf), 0);
        chk("abort_rdata_cleared", resp_rdata, 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
        end
        rst = 0;
        #1;
        chk("abort_ready", 32'(req_ready), 1);
        repeat (3) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
        end
        chk("abort_no_resp", 32'(seen), 0);
        chk("abort_mem_kept", dmem[16], 32'h11223344);
        do_req(0, 2, 0, 18'h40, 0, a_rd, a_err, a_lat, a_wf, a_w);
        chk("abort_reload", a_rd, 32'h11223344);

        // Back-to-back word loads with req_valid held high.
        for (int i = 0; i < 3; i++) begin
            model(1, 2, 0, 18'(32 + 4*i), 32'hC0DE0000 + i,
                  e_rd, e_err, e_lat, e_wf);
            do_req(1, 2, 0, 18'(32 + 4*i), 32'hC0DE0000 + i,
                   a_rd, a_err, a_lat, a_wf, a_w);
            model(0, 2, 0, 18'(32 + 4*i), 0, exp_d[i], e_err,
                  e_lat, e_wf);
        end
        wait_ready();
        n_acc = 0; n_rsp = 0;
        req_we = 0; req_size = 2; req_signed = 0;
        req_addr = 18'd32; req_wdata = 0;
        req_valid = 1;
        for (int c = 0; c < 30 && n_rsp < 3; c++) begin
            rdy_now = req_ready;
            @(posedge clk); #1;
            if (rdy_now && req_valid) begin
                acc_c[n_acc] = c;
                n_acc++;
                if (n_acc < 3) req_addr = 18'(32 + 4*n_acc);
                else req_valid = 0;
            end
            if (resp_valid && n_rsp < 3) begin
                rsp_c[n_rsp] = c;
                rsp_d[n_rsp] = resp_rdata;
                n_rsp++;
            end
        end
        req_valid = 0;
        chk("b2b_resp_count", n_rsp, 3);
        chk("b2b_acc_count", n_acc, 3);
        for (int i = 0; i < 3 && i < n_rsp && i < n_acc; i++) begin
            chk($sformatf("b2b%0d_data", i), rsp_d[i], exp_d[i]);
            chk($sformatf("b2b%0d_lat", i), rsp_c[i] - acc_c[i], 1);
            if (i > 0)
                chk($sformatf("b2b%0d_gap", i),
                    acc_c[i] - acc_c[i-1], 3);
        end

        // Random traffic over a small window of words.
        for (int i = 0; i < 200; i++) begin
            logic        r_we, r_sgn;
            logic [1:0]  r_size;
            logic [17:0] r_addr;
            logic [31:0] r_wd;
            r_we   = 1'($urandom_range(0, 1));
            r_sgn  = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3
                     : 2'($urandom_range(0, 2));
            r_addr = 18'($urandom_range(0, 63));
            r_wd   = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wd,
                  e_rd, e_err, e_lat, e_wf);
            do_req(r_we, r_size, r_sgn, r_addr, r_wd,
                   a_rd, a_err, a_lat, a_wf, a_w);
            chk($sformatf("rnd%0d_rdata", i), a_rd, e_rd);
            chk($sformatf("rnd%0d_err", i), 32'(a_err), 32'(e_err));
            chk($sformatf("rnd%0d_lat", i), a_lat, e_lat);
            chk($sformatf("rnd%0d_wf", i), 32'(a_wf), 32'(e_wf));
        end
        @(posedge clk); #1;
        for (int w = 0; w < 16; w++)
            chk($sformatf("final_mem%0d", w), dmem[w], ref_mem[w]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side controller for the CPU's word-addressed data memory. It accepts byte, halfword and word load/store requests from the execute stage using byte addresses. It drives the memory's address, write-flag and write-data pins, and returns zero- or sign-extended load data. Sub-word stores are performed as read-modify-write, because the memory only writes whole words.

## Interface

Parameters:
- N, 32, data width; only 32 is supported because byte-lane logic is fixed at 4 lanes.
- M, 16, memory address width in words; byte address width is M+2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  M+2  byte address.
- req_wdata  in  N  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle pulse marking request completion.
- resp_rdata  out  N  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned access or illegal size.
- mem_address  out  M  word address to memory.
- mem_wf  out  1  memory write flag.
- mem_w  out  N  memory write data.
- mem_v  in  N  memory read data, combinational from mem_address.

## Operation

- FSM states: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- IDLE
  - req_ready=1.
  - On req_valid, latch we/size/signed/addr/wdata.
  - If the access is misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) or size=3, go to RESP with the error flag set. No memory access occurs.
  - Otherwise, a word store goes to WRITE; every other request goes to READ.
- READ
  - mem_address = latched addr[M+1:2], mem_wf=0.
  - At the clock edge, capture mem_v into the data register.
  - Loads go to RESP; sub-word stores go to WRITE.
- WRITE
  - mem_address as in READ, mem_wf=1.
  - mem_w is the data register with the selected lanes replaced by wdata; for a word store it is wdata.
  - Then go to RESP.
- RESP
  - resp_valid=1, resp_err = error flag, req_ready=0; then go to IDLE.
- Lanes are little-endian: byte lane k (addr[1:0]=k) is bits [8k+7:8k]; halfword lane at addr[1] is bits [16·addr[1]+15:16·addr[1]].
- Load extraction: the selected lane is right-aligned, then sign-extended from its top bit if signed=1, otherwise zero-extended.
- mem_wf is asserted only in WRITE, never in any other state.
- resp_rdata and resp_err are registered and change only on entry to RESP. Outside RESP they hold their last value, but are qualified by resp_valid.

## Timing

- Accept edge A is the rising edge with state IDLE and req_valid=1.
- Load: READ in cycle A+1, resp_valid high in cycle A+2.
- Sub-word store: READ A+1, WRITE A+2 (memory updated at the end of that cycle), resp_valid in cycle A+3.
- Word store: WRITE A+1, resp_valid in cycle A+2.
- Error: resp_valid in cycle A+1, with mem_wf=0 throughout.
- Throughput: the next request can be accepted at the edge ending the cycle after RESP (IDLE). req_valid held high produces back-to-back requests separated by exactly one IDLE cycle.
- No backpressure on responses; the consumer must sample resp_* when resp_valid=1.
- Reset (asynchronous, any cycle):
  - State goes to IDLE immediately.
  - mem_wf drops within the same cycle, so a WRITE in progress is aborted and memory is unchanged.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_w=0.
  - req_ready=1 after rst deasserts.
  - No response is ever produced for an aborted request.

## Test plan

- Word store 0xDEADBEEF at byte addr 0x10, then word load from 0x10: mem word 4 = 0xDEADBEEF; the load response is 0xDEADBEEF with err=0, at cycle A+2.
- With word 4 = 0xDEADBEEF, byte store 0x55 at addr 0x12 (READ then WRITE with mem_w=0xDE55BEEF). A word load then returns 0xDE55BEEF, and the store's resp_valid arrives at cycle A+3.
- With word 4 = 0xDE55BEEF:
  - signed halfword load at addr 0x12 returns 0xFFFFDE55;
  - unsigned halfword load at 0x12 returns 0x0000DE55;
  - signed byte load at 0x10 returns 0xFFFFFFEF.
- Misaligned word load at 0x11, halfword store at 0x13, and size=3: each gives resp_err=1 and resp_rdata=0 at cycle A+1, mem_wf never rises, and memory is unchanged.
- Assert rst during the WRITE cycle of a byte store to a word holding 0x11223344: mem_wf falls immediately, the word still reads 0x11223344, no resp_valid is produced, and req_ready=1 after release.
- Hold req_valid high with three word loads: acceptances are 3 cycles apart, each producing exactly one resp_valid pulse with the correct data.
